// File: rtl/cardinal_router_inport.sv
// ---------------------------------------------------------------------------
// cardinal_router_inport
//
// Input-port stage of the cardinal ring router. It sits directly on the NIC's
// network-side output and holds one packet per virtual channel: VC0 (even) and
// VC1 (odd). Router polarity decides which VC is written and which is read in
// a given cycle. The write side is polarity and the read side is ~polarity, so
// an accept and a pop never touch the same buffer in one cycle.
//
// While a packet is accepted, its hop count is decremented. A packet that
// arrives with hop count 0 is stored unchanged and flagged for local delivery.
// A packet whose VC bit disagrees with polarity is dropped. This also sets a
// sticky error flag.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high; forces in_ri/out_so/out_local low
//   polarity   router polarity (write VC = polarity, read VC = ~polarity)
//   in_si      upstream send valid
//   in_ri      ready to accept on the current write VC
//   in_di      upstream packet
//   out_so     packet valid toward the switch (current read VC)
//   out_ro     switch ready; a pop happens when out_so && out_ro
//   out_do     packet toward the switch
//   out_local  with out_so: hop count exhausted, deliver locally
//   vc_err     sticky: a packet arrived with VC bit != polarity
//   pkt_cnt    packets accepted since reset, wraps
//
// Packet fields: [63]=VC, [62]=direction, [55:48]=hop, [47:32]=source,
// [31:0]=payload.
// ---------------------------------------------------------------------------
module cardinal_router_inport #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  in_si,
    output logic                  in_ri,
    input  logic [DATA_WIDTH-1:0] in_di,
    output logic                  out_so,
    input  logic                  out_ro,
    output logic [DATA_WIDTH-1:0] out_do,
    output logic                  out_local,
    output logic                  vc_err,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int VC_BIT = DATA_WIDTH - 1;
    localparam int HOP_HI = 55;
    localparam int HOP_LO = 48;

    // Returns the packet with its hop field decremented.
    // A zero hop count is left as it is.
    function automatic logic [DATA_WIDTH-1:0] hop_update(input logic [DATA_WIDTH-1:0] pkt);
        logic [DATA_WIDTH-1:0] res;
        res = pkt;
        if (pkt[HOP_HI:HOP_LO] != 8'd0) begin
            res[HOP_HI:HOP_LO] = pkt[HOP_HI:HOP_LO] - 8'd1;
        end else begin
            res[HOP_HI:HOP_LO] = pkt[HOP_HI:HOP_LO];
        end
        return res;
    endfunction

    // True when the packet has no hops left and must be delivered here.
    function automatic logic hop_exhausted(input logic [DATA_WIDTH-1:0] pkt);
        return (pkt[HOP_HI:HOP_LO] == 8'd0);
    endfunction

    logic [1:0][DATA_WIDTH-1:0] pkt_buf_q, pkt_buf_d;
    logic [1:0]                 full_q, full_d;
    logic [1:0]                 local_q, local_d;
    logic                       vc_err_q, vc_err_d;
    logic [CNT_WIDTH-1:0]       pkt_cnt_q, pkt_cnt_d;

    logic wr_vc_s;
    logic rd_vc_s;
    logic accept_s;
    logic vc_match_s;
    logic pop_s;

    // Handshake decode.
    // The write VC follows polarity and the read VC is the other one.
    always_comb begin
        wr_vc_s    = polarity;
        rd_vc_s    = ~polarity;
        in_ri      = !reset && !full_q[wr_vc_s];
        out_so     = !reset && full_q[rd_vc_s];
        out_do     = pkt_buf_q[rd_vc_s];
        out_local  = out_so && local_q[rd_vc_s];
        accept_s   = in_si && in_ri;
        vc_match_s = (in_di[VC_BIT] == wr_vc_s);
        pop_s      = out_so && out_ro;
    end

    // Next-state logic for the buffers, flags and counter.
    // The accept and the pop address different VCs, so both can apply in one cycle.
    always_comb begin
        pkt_buf_d = pkt_buf_q;
        full_d    = full_q;
        local_d   = local_q;
        vc_err_d  = vc_err_q;
        pkt_cnt_d = pkt_cnt_q;
        if (accept_s) begin
            if (vc_match_s) begin
                pkt_buf_d[wr_vc_s] = hop_update(in_di);
                local_d[wr_vc_s]   = hop_exhausted(in_di);
                full_d[wr_vc_s]    = 1'b1;
                pkt_cnt_d          = pkt_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                vc_err_d = 1'b1;
            end
        end else begin
            vc_err_d = vc_err_q;
        end
        if (pop_s) begin
            full_d[rd_vc_s] = 1'b0;
        end else begin
            full_d[rd_vc_s] = full_d[rd_vc_s];
        end
    end

    // Control state register. Reset discards buffered packets and clears the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= 2'b00;
            local_q   <= 2'b00;
            vc_err_q  <= 1'b0;
            pkt_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            full_q    <= full_d;
            local_q   <= local_d;
            vc_err_q  <= vc_err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Packet storage. Its contents only matter while the matching full bit is set.
    always_ff @(posedge clk) begin
        pkt_buf_q <= pkt_buf_d;
    end

    // Status outputs come straight from their registers.
    always_comb begin
        vc_err  = vc_err_q;
        pkt_cnt = pkt_cnt_q;
    end

endmodule

// File: tb/tb_cardinal_router_inport.sv
// ---------------------------------------------------------------------------
// tb_cardinal_router_inport
//
// Directed bench for cardinal_router_inport.
// - Stimulus tasks push the hand-computed expected packet into a per-VC queue
//   when a send is meant to be accepted.
// - A monitor samples on the falling edge. It checks out_so against the
//   expected occupancy. It compares the presented packet with the queue head
//   and pops the head whenever the switch takes the packet.
// ---------------------------------------------------------------------------
module tb_cardinal_router_inport;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        in_si;
    logic        in_ri;
    logic [63:0] in_di;
    logic        out_so;
    logic        out_ro;
    logic [63:0] out_do;
    logic        out_local;
    logic        vc_err;
    logic [15:0] pkt_cnt;

    typedef struct packed {
        logic [63:0] d;
        logic        loc;
    } exp_t;

    exp_t     q0[$];
    exp_t     q1[$];
    bit [1:0] mfull;
    int       pops;
    int       checks;
    int       errors;

    cardinal_router_inport #(
        .DATA_WIDTH(64),
        .CNT_WIDTH (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .in_si    (in_si),
        .in_ri    (in_ri),
        .in_di    (in_di),
        .out_so   (out_so),
        .out_ro   (out_ro),
        .out_do   (out_do),
        .out_local(out_local),
        .vc_err   (vc_err),
        .pkt_cnt  (pkt_cnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polarity is held at 0 during reset and toggles every cycle afterwards.
    // It changes 1 time unit after the edge, before the stimulus moves.
    initial begin
        polarity = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            polarity = reset ? 1'b0 : ~polarity;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to the stimulus point of the next cycle and drop in_si by default.
    task automatic next_cycle();
        @(posedge clk);
        #2;
        in_si = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // Offer packet d in the next cycle where polarity == vc.
    // exp_ri is the hand-derived readiness for that cycle. exp_d and exp_loc
    // describe the stored packet when the send is accepted with a matching VC.
    task automatic send(input bit vc, input logic [63:0] d, input logic [63:0] exp_d,
                        input bit exp_loc, input bit exp_ri);
        int k;
        next_cycle();
        k = 0;
        while (polarity != vc && k < 4) begin
            next_cycle();
            k++;
        end
        checks++;
        if (polarity != vc) begin
            errors++;
            $display("FAIL send_wait actual_polarity=%0d required=%0d", polarity, vc);
        end
        in_si = 1'b1;
        in_di = d;
        @(negedge clk);
        chk("in_ri", in_ri, exp_ri);
        if (exp_ri && d[63] == vc) begin
            if (vc) q1.push_back('{d: exp_d, loc: exp_loc});
            else    q0.push_back('{d: exp_d, loc: exp_loc});
            mfull[vc] = 1'b1;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mfull = 2'b00;
    endtask

    // Monitor: checks the read side every cycle and retires packets as they pop.
    initial begin : mon
        exp_t h;
        bit   r;
        bit   rst_d1;
        int   n;
        rst_d1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_in_ri", in_ri, 1'b0);
                chk("rst_out_so", out_so, 1'b0);
                chk("rst_out_local", out_local, 1'b0);
                if (rst_d1) begin
                    chk("rst_pkt_cnt", pkt_cnt, 16'd0);
                    chk("rst_vc_err", vc_err, 1'b0);
                end
            end else begin
                r = ~polarity;
                chk("out_so", out_so, mfull[r]);
                if (mfull[r] && out_so) begin
                    n = r ? q1.size() : q0.size();
                    if (n == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty actual_vc=%0d required=no_packet", r);
                    end else begin
                        h = r ? q1[0] : q0[0];
                        chk("out_do", out_do, h.d);
                        chk("out_local", out_local, h.loc);
                        if (out_ro) begin
                            if (r) void'(q1.pop_front());
                            else   void'(q0.pop_front());
                            mfull[r] = 1'b0;
                            pops++;
                        end
                    end
                end
            end
            rst_d1 = reset;
        end
    end

    // Hard time limit so that a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    // Main directed sequence.
    initial begin
        logic [63:0] d;
        logic [63:0] e;
        checks = 0;
        errors = 0;
        pops   = 0;
        mfull  = 2'b00;
        reset  = 1'b1;
        in_si  = 1'b1;
        in_di  = 64'hFFFF_FFFF_FFFF_FFFF;
        out_ro = 1'b1;

        // T1: reset for 4 cycles with in_si held high.
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        in_si = 1'b0;
        chk("t1_pkt_cnt", pkt_cnt, 16'd0);

        // T2: VC0 with hop 5 is stored with hop 4 and offered the next cycle.
        send(1'b0, 64'h0005_0001_0000_00AA, 64'h0004_0001_0000_00AA, 1'b0, 1'b1);
        idle(3);
        chk("t2_pkt_cnt", pkt_cnt, 16'd1);
        chk("t2_drained", q0.size(), 64'd0);

        // T3: VC1 with hop 0 is stored unchanged and flagged local.
        send(1'b1, 64'h8000_0002_0000_00BB, 64'h8000_0002_0000_00BB, 1'b1, 1'b1);
        idle(3);
        chk("t3_drained", q1.size(), 64'd0);

        // T4: the switch stalls, a second VC0 send is refused, then accepted after the pop.
        out_ro = 1'b0;
        send(1'b0, 64'h4003_0004_1234_5678, 64'h4002_0004_1234_5678, 1'b0, 1'b1);
        send(1'b0, 64'h0007_0005_0000_0001, 64'h0006_0005_0000_0001, 1'b0, 1'b0);
        idle(4);
        out_ro = 1'b1;
        idle(2);
        send(1'b0, 64'h0007_0005_0000_0001, 64'h0006_0005_0000_0001, 1'b0, 1'b1);
        idle(3);
        chk("t4_pkt_cnt", pkt_cnt, 16'd4);

        // T5: a VC-mismatched packet is dropped and sets the sticky error.
        chk("t5_vc_err_before", vc_err, 1'b0);
        send(1'b0, 64'h8001_0003_0000_00CC, 64'h0, 1'b0, 1'b1);
        idle(1);
        chk("t5_vc_err", vc_err, 1'b1);
        chk("t5_pkt_cnt", pkt_cnt, 16'd4);
        idle(4);
        chk("t5_vc_err_sticky", vc_err, 1'b1);

        // T6: reset, then send 10 alternating packets with the switch always ready.
        reset = 1'b1;
        model_reset();
        idle(2);
        reset = 1'b0;
        pops  = 0;
        for (int i = 0; i < 10; i++) begin
            d = {i[0], 7'h00, 8'(i + 2), 16'(16'h0100 + i), 32'(32'hCAFE_0000 + i)};
            e = {i[0], 7'h00, 8'(i + 1), 16'(16'h0100 + i), 32'(32'hCAFE_0000 + i)};
            send(i[0], d, e, 1'b0, 1'b1);
        end
        idle(3);
        chk("t6_pops", pops, 64'd10);
        chk("t6_pkt_cnt", pkt_cnt, 16'd10);
        chk("t6_vc_err", vc_err, 1'b0);

        // Fill both VCs, then reset mid-operation.
        out_ro = 1'b0;
        send(1'b0, 64'h0002_0009_0000_0011, 64'h0001_0009_0000_0011, 1'b0, 1'b1);
        send(1'b1, 64'hC000_0009_0000_0022, 64'hC000_0009_0000_0022, 1'b1, 1'b1);
        idle(2);
        reset = 1'b1;
        model_reset();
        idle(2);
        reset  = 1'b0;
        out_ro = 1'b1;
        idle(3);
        chk("t6_post_rst_cnt", pkt_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
